// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle 9-bit ISA core with handshaked instruction
// and data memories. Each instruction walks FETCH/DECODE/EXEC/[MEM]/WB;
// the all-ones J encoding parks the core in HALT until the next start.
module multicycle_core #(
  parameter int D  = 10,
  parameter int W  = 8,
  parameter int NR = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         done,
  output logic         imem_req,
  output logic [D-1:0] imem_addr,
  input  logic [8:0]   imem_data,
  input  logic         imem_ack,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [W-1:0] dmem_addr,
  output logic [W-1:0] dmem_wdata,
  input  logic [W-1:0] dmem_rdata,
  input  logic         dmem_ack,
  output logic [15:0]  icount
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_XOR, OP_BEQ, OP_ADDI, OP_ANDI, OP_LS, OP_LD, OP_ST, OP_J
  } opcode_t;

  localparam logic [8:0] HALT_ENC = 9'h1FF;

  state_t         state, state_nxt;
  logic [D-1:0]   pc, npc, npc_c;
  logic [8:0]     ir;
  logic [W-1:0]   rf [NR];
  logic [W-1:0]   opa, opb, res, alu;

  opcode_t        op;
  logic [2:0]     ra, rb, imm3;
  logic [W-1:0]   imm_z;
  logic [D-1:0]   sext3, sext6, pc_inc;
  logic           wr_en, is_mem;

  assign op     = opcode_t'(ir[8:6]);
  assign ra     = ir[5:3];
  assign rb     = ir[2:0];
  assign imm3   = ir[2:0];
  assign imm_z  = {{(W-3){1'b0}}, imm3};
  assign sext3  = {{(D-3){ir[2]}}, ir[2:0]};
  assign sext6  = {{(D-6){ir[5]}}, ir[5:0]};
  assign pc_inc = pc + {{(D-1){1'b0}}, 1'b1};
  assign is_mem = (op == OP_LD) || (op == OP_ST);
  assign wr_en  = (op == OP_XOR) || (op == OP_ADDI) || (op == OP_ANDI) ||
                  (op == OP_LS)  || (op == OP_LD);

  // Handshake strobes and done are pure decodes of the registered state,
  // so nothing on an input can reach an output combinationally.
  assign imem_req  = (state == S_FETCH);
  assign dmem_req  = (state == S_MEM);
  assign done      = (state == S_HALT);
  assign imem_addr = pc;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; acks only matter in the state that raised the req
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = (ir == HALT_ENC) ? S_HALT : S_EXEC;
      S_EXEC:   state_nxt = is_mem ? S_MEM : S_WB;
      S_MEM:    if (dmem_ack) state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   if (start) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ALU result and next PC from the latched operands
  always_comb begin
    alu   = opa;
    npc_c = pc_inc;
    case (op)
      OP_XOR:  alu = opa ^ opb;
      OP_BEQ:  if (opa == '0) npc_c = pc + sext3;
      OP_ADDI: alu = opa + imm_z;
      OP_ANDI: alu = opa & imm_z;
      OP_LS:   alu = opa << imm3;   // amounts >= W shift everything out
      OP_J:    npc_c = pc + sext6;
      default: ;
    endcase
  end

  // Datapath: each state owns the registers it updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= '0;
      npc        <= '0;
      ir         <= '0;
      opa        <= '0;
      opb        <= '0;
      res        <= '0;
      icount     <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      for (int i = 0; i < NR; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          // registers are deliberately kept across a restart from HALT
          if (start) begin
            pc     <= '0;
            icount <= '0;
          end
        end
        S_FETCH: if (imem_ack) ir <= imem_data;
        S_DECODE: begin
          opa <= rf[ra];
          opb <= rf[rb];
        end
        S_EXEC: begin
          res        <= alu;
          npc        <= npc_c;
          // address/data/we are set up here so they are already stable
          // on the edge that raises dmem_req
          dmem_we    <= (op == OP_ST);
          dmem_addr  <= opb;
          dmem_wdata <= opa;
        end
        S_MEM: if (dmem_ack && op == OP_LD) res <= dmem_rdata;
        S_WB: begin
          if (wr_en) rf[ra] <= res;
          pc <= npc;
          if (icount != 16'hFFFF) icount <= icount + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small programs run against simple
// imem/dmem models with programmable wait states; stores are captured and
// compared to hand-computed values, as are completion latencies.
module tb_multicycle_core;

  logic clk = 1'b0;
  logic rst, start, start16;
  always #5 clk = ~clk;

  // 8-bit core signals
  logic        done, imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [9:0]  imem_addr;
  logic [8:0]  imem_data;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [15:0] icount;

  // 16-bit core signals
  logic        done16, imem_req16, dmem_req16, dmem_we16;
  logic [9:0]  imem_addr16;
  logic [8:0]  imem_data16;
  logic [15:0] dmem_addr16, dmem_wdata16, icount16;

  logic [8:0] prog [0:1023];
  logic [7:0] dmem [0:255];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  int st_cnt = 0, st16_cnt = 0, nwait = 0, viol = 0;
  logic [7:0]  st_addr = '0, st_data = '0;
  logic [15:0] st16_data = '0;
  logic        pend = 1'b0;
  logic [9:0]  pend_addr = '0;
  int nchk = 0, nerr = 0;

  assign imem_ack    = imem_req && (icnt == iwait);
  assign dmem_ack    = dmem_req && (dcnt == dwait);
  assign imem_data   = prog[imem_addr];
  assign dmem_rdata  = dmem[dmem_addr];
  assign imem_data16 = prog[imem_addr16];

  multicycle_core #(.D(10), .W(8), .NR(8)) dut (
    .clk(clk), .reset(rst), .start(start), .done(done),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .icount(icount)
  );

  multicycle_core #(.D(10), .W(16), .NR(8)) dut16 (
    .clk(clk), .reset(rst), .start(start16), .done(done16),
    .imem_req(imem_req16), .imem_addr(imem_addr16), .imem_data(imem_data16), .imem_ack(imem_req16),
    .dmem_req(dmem_req16), .dmem_we(dmem_we16), .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16),
    .dmem_rdata(16'h0000), .dmem_ack(dmem_req16), .icount(icount16)
  );

  // memory wait counters, store capture, fetch-wait tracking
  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we) begin
      st_cnt  <= st_cnt + 1;
      st_addr <= dmem_addr;
      st_data <= dmem_wdata;
    end
    if (dmem_req16 && dmem_we16) begin
      st16_cnt  <= st16_cnt + 1;
      st16_data <= dmem_wdata16;
    end
    pend      <= imem_req && !imem_ack;
    pend_addr <= imem_addr;
  end

  // a fetch still waiting must keep req high and the address unchanged
  always @(negedge clk) begin
    if (pend && !rst) begin
      nwait <= nwait + 1;
      if (!imem_req || imem_addr != pend_addr) viol <= viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] enc(input int op, input int ra, input int rb);
    logic [2:0] o, a, b;
    o = 3'(op); a = 3'(ra); b = 3'(rb);
    return {o, a, b};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) prog[i] = 9'h1FF;
  endtask

  // ADDI r1,5 / ADDI r1,3 / ST r1,[r0] / HALT
  task automatic load_a();
    clear_prog();
    prog[0] = enc(2, 1, 5);
    prog[1] = enc(2, 1, 3);
    prog[2] = enc(6, 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  // pulse start, return done/icount just after the start edge and the
  // number of edges from the start edge to the one entering HALT
  task automatic run(output int edges, output logic d0, output logic [15:0] ic0);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done; ic0 = icount; edges = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (done) begin edges = n; break; end
    end
  endtask

  initial begin
    int e, base, n;
    logic d0;
    logic [15:0] ic0;
    rst = 1'b1; start = 1'b0; start16 = 1'b0;
    for (int i = 0; i < 256; i++) dmem[i] = 8'(i);
    clear_prog();
    repeat (2) @(posedge clk); #1;
    check("rst_done", done, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_icount", icount, 0);
    @(negedge clk) rst = 1'b0;

    // basic program, zero wait
    load_a(); base = st_cnt;
    run(e, d0, ic0);
    check("a_edges", e, 15);
    check("a_stores", st_cnt - base, 1);
    check("a_addr", st_addr, 0);
    check("a_data", st_data, 8);
    check("a_icount", icount, 3);
    check("a_imem_req_halt", imem_req, 0);

    // restart from HALT: registers preserved, counter restarts
    base = st_cnt;
    run(e, d0, ic0);
    check("re_done_fall", d0, 0);
    check("re_icount0", ic0, 0);
    check("re_edges", e, 15);
    check("re_data", st_data, 16);
    check("re_icount", icount, 3);

    // three wait cycles on every fetch
    do_reset(); iwait = 3; base = st_cnt;
    run(e, d0, ic0);
    check("iw_edges", e, 27);
    check("iw_data", st_data, 8);
    check("iw_stores", st_cnt - base, 1);
    check("iw_wait_cycles", nwait, 12);
    check("iw_stable", viol, 0);
    iwait = 0;

    // reset while a store is waiting in MEM
    do_reset(); dwait = 10; base = st_cnt;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!dmem_req && n < 100) begin @(posedge clk); #1; n++; end
    check("mr_reached_mem", dmem_req, 1);
    check("mr_icount_pre", icount, 2);
    #2 rst = 1'b1;
    #1;
    check("mr_dmem_req", dmem_req, 0);
    check("mr_done", done, 0);
    check("mr_icount", icount, 0);
    check("mr_imem_req", imem_req, 0);
    check("mr_no_store", st_cnt - base, 0);
    @(negedge clk) rst = 1'b0;
    dwait = 0;
    run(e, d0, ic0);
    check("mr_edges", e, 15);
    check("mr_data", st_data, 8);

    // BEQ taken on zero register: ADDI skipped
    do_reset(); clear_prog();
    prog[0] = enc(1, 1, 2); prog[1] = enc(2, 3, 7); prog[2] = enc(6, 3, 0);
    run(e, d0, ic0);
    check("beq_t_edges", e, 11);
    check("beq_t_data", st_data, 0);
    check("beq_t_icount", icount, 2);

    // BEQ not taken with r1=1: ADDI executes
    do_reset(); clear_prog();
    prog[0] = enc(2, 1, 1); prog[1] = enc(1, 1, 2); prog[2] = enc(2, 3, 7);
    prog[3] = enc(6, 3, 0);
    run(e, d0, ic0);
    check("beq_n_edges", e, 19);
    check("beq_n_data", st_data, 7);

    // LD 0xFF, shift left by 7 at W=8
    do_reset(); clear_prog(); dmem[0] = 8'hFF;
    prog[0] = enc(5, 1, 0); prog[1] = enc(4, 1, 7); prog[2] = enc(6, 1, 0);
    run(e, d0, ic0);
    check("ls_edges", e, 16);
    check("ls_data", st_data, 8'h80);

    // W=16: ADDI r1,7 / LS r1,4 / ST r1,[r0] / HALT
    clear_prog(); base = st16_cnt;
    prog[0] = enc(2, 1, 7); prog[1] = enc(4, 1, 4); prog[2] = enc(6, 1, 0);
    @(negedge clk) start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    e = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (done16) begin e = k; break; end
    end
    check("w16_edges", e, 15);
    check("w16_stores", st16_cnt - base, 1);
    check("w16_data", st16_data, 16'h0070);
    check("w16_icount", icount16, 3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
